// File: rtl/xgmii_lb_chan.sv
// xgmii_lb_chan: XGMII loopback channel with a programmable delay line.
// TX words come back on the RX side after 1 + act_dly cycles, or the
// output is replaced by Idle or Local Fault ordered sets. Mode and delay
// changes wait until the line holds no frame data, so frames are never cut.
// Optional macro XGMII_LB_ERRINJ_EN adds the inj_err port and a one-shot
// lane-0 Error injection into looped frames.
module xgmii_lb_chan #(
    parameter int DATA_W  = 64,
    parameter int MAX_DLY = 16,
    parameter int DLY_W   = $clog2(MAX_DLY),
    parameter int CNT_W   = 16
) (
    input  logic                clk_xgmii_tx,
    input  logic                reset_xgmii_tx_n,
`ifdef XGMII_LB_ERRINJ_EN
    input  logic                inj_err,
`endif
    input  logic [DATA_W-1:0]   xgmii_txd,
    input  logic [DATA_W/8-1:0] xgmii_txc,
    input  logic [1:0]          cfg_mode,
    input  logic [DLY_W-1:0]    cfg_dly,
    output logic                cfg_pending,
    output logic [DATA_W-1:0]   xgmii_rxd,
    output logic [DATA_W/8-1:0] xgmii_rxc,
    output logic [CNT_W-1:0]    frm_cnt,
    output logic                in_frame
);

    localparam int LANES    = DATA_W / 8;
    localparam int HALVES   = DATA_W / 32;
    localparam int WORD_W   = DATA_W + LANES;
    localparam int GAP_W    = $clog2(MAX_DLY + 1);
    localparam int DLY_LAST = MAX_DLY - 1;

    localparam logic [DATA_W-1:0] IDLE_D   = {LANES{8'h07}};
    localparam logic [LANES-1:0]  IDLE_C   = {LANES{1'b1}};
    localparam logic [DATA_W-1:0] LF_D     = {HALVES{32'h0100009C}};
    localparam logic [LANES-1:0]  LF_C     = {HALVES{4'b0001}};
    localparam logic [WORD_W-1:0] IDLE_W   = {IDLE_C, IDLE_D};
    localparam logic [GAP_W-1:0]  GAP_FULL = GAP_W'(MAX_DLY);

    typedef enum logic {STABLE, PENDING} cfg_state_t;

    // Start may only sit in lane 0, or lane 4 on a 64-bit bus
    function automatic logic is_start(input logic [WORD_W-1:0] w);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if ((k == 0 || k == 4) && w[DATA_W + k] && (w[8*k +: 8] == 8'hFB))
                hit = 1'b1;
        end
        return hit;
    endfunction

    // Terminate may appear in any lane
    function automatic logic is_term(input logic [WORD_W-1:0] w);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (w[DATA_W + k] && (w[8*k +: 8] == 8'hFD))
                hit = 1'b1;
        end
        return hit;
    endfunction

    logic [WORD_W-1:0] line [0:MAX_DLY-2];
    logic [WORD_W-1:0] taps [0:MAX_DLY-1];
    logic [WORD_W-1:0] in_word;
    logic [WORD_W-1:0] tap_word;
    logic              in_start;
    logic              in_term;
    logic [GAP_W-1:0]  gap_cnt;
    logic [1:0]        act_mode;
    logic [DLY_W-1:0]  act_dly;
    logic [DLY_W-1:0]  req_dly;
    logic              req_differs;
    logic              load;
    logic              inject;
    logic [DATA_W-1:0] loop_d;
    logic [LANES-1:0]  loop_c;
    cfg_state_t        state;
    cfg_state_t        state_nxt;

    assign in_word     = {xgmii_txc, xgmii_txd};
    assign in_start    = is_start(in_word);
    assign in_term     = is_term(in_word);
    assign tap_word    = taps[act_dly];
    assign req_differs = ({cfg_mode, cfg_dly} != {act_mode, act_dly});
    assign cfg_pending = (state == PENDING);

    // Tap 0 is the live input so that the output register alone gives one cycle of latency
    always_comb begin
        taps[0] = in_word;
        for (int i = 1; i < MAX_DLY; i++)
            taps[i] = line[i-1];
    end

    // Delay line shifts every cycle regardless of mode
    always_ff @(posedge clk_xgmii_tx or negedge reset_xgmii_tx_n) begin
        if (!reset_xgmii_tx_n) begin
            for (int i = 0; i < MAX_DLY - 1; i++)
                line[i] <= IDLE_W;
        end else begin
            line[0] <= in_word;
            for (int i = 1; i < MAX_DLY - 1; i++)
                line[i] <= line[i-1];
        end
    end

    // Out-of-range delay requests are clamped to the deepest tap when loaded
    always_comb begin
        req_dly = cfg_dly;
        if (int'(cfg_dly) > DLY_LAST)
            req_dly = DLY_W'(DLY_LAST);
    end

    // Input-side frame tracking and saturating Start counter
    always_ff @(posedge clk_xgmii_tx or negedge reset_xgmii_tx_n) begin
        if (!reset_xgmii_tx_n) begin
            in_frame <= 1'b0;
            frm_cnt  <= '0;
        end else begin
            if (in_start && !in_term)
                in_frame <= 1'b1;
            else if (in_term)
                in_frame <= 1'b0;
            if (in_start && (frm_cnt != {CNT_W{1'b1}}))
                frm_cnt <= frm_cnt + 1'b1;
        end
    end

    // Quiet-line counter: reaches MAX_DLY once the whole line is free of frame data
    always_ff @(posedge clk_xgmii_tx or negedge reset_xgmii_tx_n) begin
        if (!reset_xgmii_tx_n)
            gap_cnt <= '0;
        else if (in_start || in_frame)
            gap_cnt <= '0;
        else if (gap_cnt != GAP_FULL)
            gap_cnt <= gap_cnt + 1'b1;
    end

    // Config state register
    always_ff @(posedge clk_xgmii_tx or negedge reset_xgmii_tx_n) begin
        if (!reset_xgmii_tx_n)
            state <= STABLE;
        else
            state <= state_nxt;
    end

    // Config next-state: hold a differing request until the line is quiet
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            STABLE: begin
                if (req_differs)
                    state_nxt = PENDING;
            end
            PENDING: begin
                if (!req_differs) begin
                    state_nxt = STABLE;
                end else if (gap_cnt == GAP_FULL) begin
                    load      = 1'b1;
                    state_nxt = STABLE;
                end
            end
            default: state_nxt = STABLE;
        endcase
    end

    // Active configuration, reset to forced Idle with no extra delay
    always_ff @(posedge clk_xgmii_tx or negedge reset_xgmii_tx_n) begin
        if (!reset_xgmii_tx_n) begin
            act_mode <= 2'd1;
            act_dly  <= '0;
        end else if (load) begin
            act_mode <= cfg_mode;
            act_dly  <= req_dly;
        end
    end

`ifdef XGMII_LB_ERRINJ_EN
    logic armed;
    logic out_frame;

    assign inject = armed && (act_mode == 2'd0) && out_frame && !is_start(tap_word);

    // Frame state of the word stream leaving the delay line
    always_ff @(posedge clk_xgmii_tx or negedge reset_xgmii_tx_n) begin
        if (!reset_xgmii_tx_n)
            out_frame <= 1'b0;
        else if (is_start(tap_word) && !is_term(tap_word))
            out_frame <= 1'b1;
        else if (is_term(tap_word))
            out_frame <= 1'b0;
    end

    // One-shot: arm on a pulse, disarm after the single corrupted word
    always_ff @(posedge clk_xgmii_tx or negedge reset_xgmii_tx_n) begin
        if (!reset_xgmii_tx_n)
            armed <= 1'b0;
        else if (inject)
            armed <= 1'b0;
        else if (inj_err)
            armed <= 1'b1;
    end
`else
    assign inject = 1'b0;
`endif

    // Looped word, with lane 0 turned into an Error character when injecting
    always_comb begin
        loop_d = tap_word[DATA_W-1:0];
        loop_c = tap_word[WORD_W-1:DATA_W];
        if (inject) begin
            loop_d[7:0] = 8'hFE;
            loop_c[0]   = 1'b1;
        end
    end

    // RX output register selects looped data or a forced ordered set
    always_ff @(posedge clk_xgmii_tx or negedge reset_xgmii_tx_n) begin
        if (!reset_xgmii_tx_n) begin
            xgmii_rxd <= IDLE_D;
            xgmii_rxc <= IDLE_C;
        end else begin
            case (act_mode)
                2'd0: begin
                    xgmii_rxd <= loop_d;
                    xgmii_rxc <= loop_c;
                end
                2'd2: begin
                    xgmii_rxd <= LF_D;
                    xgmii_rxc <= LF_C;
                end
                default: begin
                    xgmii_rxd <= IDLE_D;
                    xgmii_rxc <= IDLE_C;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xgmii_lb_chan.sv
// tb_xgmii_lb_chan: self-checking bench for xgmii_lb_chan (64-bit, MAX_DLY 16).
// A behavioural model built from history of input words predicts every output
// each cycle; directed literal checks pin latency, forced sets, saturation and reset.
// Define XGMII_LB_ERRINJ_EN to include the error injection scenario.
module tb_xgmii_lb_chan;

    localparam int DATA_W  = 64;
    localparam int LANES   = 8;
    localparam int MAX_DLY = 16;
    localparam int DLY_W   = 4;
    localparam int CNT_W   = 16;

    localparam logic [63:0] IDLE_D = 64'h0707070707070707;
    localparam logic [63:0] LF_D   = 64'h0100009C0100009C;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [63:0]       txd = IDLE_D;
    logic [7:0]        txc = 8'hFF;
    logic [1:0]        cfg_mode = 2'd1;
    logic [DLY_W-1:0]  cfg_dly = '0;
    logic              cfg_pending;
    logic [63:0]       rxd;
    logic [7:0]        rxc;
    logic [CNT_W-1:0]  frm_cnt;
    logic              in_frame;
`ifdef XGMII_LB_ERRINJ_EN
    logic              inj_err = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    xgmii_lb_chan #(
        .DATA_W(DATA_W), .MAX_DLY(MAX_DLY), .DLY_W(DLY_W), .CNT_W(CNT_W)
    ) dut (
        .clk_xgmii_tx(clk),
        .reset_xgmii_tx_n(rst_n),
`ifdef XGMII_LB_ERRINJ_EN
        .inj_err(inj_err),
`endif
        .xgmii_txd(txd),
        .xgmii_txc(txc),
        .cfg_mode(cfg_mode),
        .cfg_dly(cfg_dly),
        .cfg_pending(cfg_pending),
        .xgmii_rxd(rxd),
        .xgmii_rxc(rxc),
        .frm_cnt(frm_cnt),
        .in_frame(in_frame)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Drive one input word just after the falling edge
    task automatic applyStimulus(input logic [7:0] c, input logic [63:0] d);
        @(negedge clk);
        #1;
        txc = c;
        txd = d;
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(8'hFF, IDLE_D);
    endtask

    // Frame of 10 words: Start/preamble, 8 data words (64 bytes), Terminate
    function automatic logic [71:0] frame_word(input int i);
        if (i == 0)
            return {8'h01, 64'hD5555555555555FB};
        else if (i == 9)
            return {8'hFF, 64'h07070707070707FD};
        else
            return {8'h00, {8{8'(8'h10 + i)}}};
    endfunction

    function automatic logic m_start(input logic [71:0] w);
        return (w[64] && w[7:0] == 8'hFB) || (w[68] && w[39:32] == 8'hFB);
    endfunction

    function automatic logic m_term(input logic [71:0] w);
        logic t;
        t = 1'b0;
        for (int k = 0; k < LANES; k++)
            if (w[64 + k] && w[8*k +: 8] == 8'hFD) t = 1'b1;
        return t;
    endfunction

    // Behavioural model state
    logic [71:0] hist [0:MAX_DLY-1];
    int          m_mode, m_dly, m_gap;
    logic        m_pend, m_inframe;
    int          m_cnt;
    logic [63:0] exp_rxd;
    logic [7:0]  exp_rxc;
`ifdef XGMII_LB_ERRINJ_EN
    logic        m_armed, m_outframe;
`endif

    // Model: output = word from dly cycles ago (or forced set); config applies after a quiet line
    always @(posedge clk) begin
        logic [71:0] cur, tw;
        int          req_mode, req_dly;
        logic        s, t;
        if (!rst_n) begin
            for (int i = 0; i < MAX_DLY; i++) hist[i] = {8'hFF, IDLE_D};
            m_mode = 1; m_dly = 0; m_gap = 0; m_pend = 1'b0;
            m_inframe = 1'b0; m_cnt = 0;
            exp_rxd = IDLE_D; exp_rxc = 8'hFF;
`ifdef XGMII_LB_ERRINJ_EN
            m_armed = 1'b0; m_outframe = 1'b0;
`endif
        end else begin
            cur = {txc, txd};
            tw = (m_dly == 0) ? cur : hist[m_dly - 1];
            if (m_mode == 0) begin
                exp_rxd = tw[63:0];
                exp_rxc = tw[71:64];
`ifdef XGMII_LB_ERRINJ_EN
                if (m_armed && m_outframe && !m_start(tw)) begin
                    exp_rxd[7:0] = 8'hFE;
                    exp_rxc[0] = 1'b1;
                    m_armed = 1'b0;
                end else if (inj_err) begin
                    m_armed = 1'b1;
                end
`endif
            end else begin
`ifdef XGMII_LB_ERRINJ_EN
                if (inj_err) m_armed = 1'b1;
`endif
                exp_rxd = (m_mode == 2) ? LF_D : IDLE_D;
                exp_rxc = (m_mode == 2) ? 8'h11 : 8'hFF;
            end
`ifdef XGMII_LB_ERRINJ_EN
            if (m_start(tw) && !m_term(tw)) m_outframe = 1'b1;
            else if (m_term(tw)) m_outframe = 1'b0;
`endif
            req_mode = int'(cfg_mode);
            req_dly = int'(cfg_dly);
            if (!m_pend) begin
                m_pend = (req_mode != m_mode) || (req_dly != m_dly);
            end else if (req_mode == m_mode && req_dly == m_dly) begin
                m_pend = 1'b0;
            end else if (m_gap == MAX_DLY) begin
                m_mode = req_mode;
                m_dly = (req_dly > MAX_DLY - 1) ? MAX_DLY - 1 : req_dly;
                m_pend = 1'b0;
            end
            s = m_start(cur);
            t = m_term(cur);
            m_gap = (s || m_inframe) ? 0 : ((m_gap < MAX_DLY) ? m_gap + 1 : MAX_DLY);
            if (s && m_cnt < 16'hFFFF) m_cnt++;
            if (s && !t) m_inframe = 1'b1;
            else if (t) m_inframe = 1'b0;
            for (int i = MAX_DLY - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = cur;
        end
    end

    // Compare every cycle outside reset
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("model_rxd", rxd, exp_rxd);
            checkOutput("model_rxc", 64'(rxc), 64'(exp_rxc));
            checkOutput("model_frm_cnt", 64'(frm_cnt), 64'(m_cnt));
            checkOutput("model_in_frame", 64'(in_frame), 64'(m_inframe));
            checkOutput("model_cfg_pending", 64'(cfg_pending), 64'(m_pend));
        end
    end

    // Directed scenarios
    initial begin
        logic [71:0] w;
        logic        saw_pend;
        logic [71:0] sw;
        sw = {8'h81, 8'hFD, 48'h0, 8'hFB};

        // Reset, then loop mode with no extra delay
        idles(3);
        checkOutput("reset_rxd", rxd, IDLE_D);
        checkOutput("reset_rxc", 64'(rxc), 64'hFF);
        checkOutput("reset_frm_cnt", 64'(frm_cnt), 64'h0);
        checkOutput("reset_pending", 64'(cfg_pending), 64'h0);
        rst_n = 1'b1;
        cfg_mode = 2'd0;
        cfg_dly = 4'd0;
        idles(30);
        checkOutput("cfg0_settled", 64'(cfg_pending), 64'h0);
        for (int i = 0; i < 10; i++) begin
            w = frame_word(i);
            applyStimulus(w[71:64], w[63:0]);
            if (i > 0) begin
                w = frame_word(i - 1);
                checkOutput("dly0_rxd", rxd, w[63:0]);
                checkOutput("dly0_rxc", 64'(rxc), 64'(w[71:64]));
            end
            if (i == 1) checkOutput("in_frame_set", 64'(in_frame), 64'h1);
        end
        idles(1);
        checkOutput("dly0_term", rxd, 64'h07070707070707FD);
        checkOutput("frm_cnt_one", 64'(frm_cnt), 64'h1);
        checkOutput("in_frame_clear", 64'(in_frame), 64'h0);

        // Delay change while idle
        cfg_dly = 4'd5;
        saw_pend = 1'b0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(8'hFF, IDLE_D);
            if (cfg_pending) saw_pend = 1'b1;
        end
        checkOutput("dly5_pend_pulse", 64'(saw_pend), 64'h1);
        checkOutput("dly5_pend_done", 64'(cfg_pending), 64'h0);
        applyStimulus(8'h01, 64'hD5555555555555FB);
        for (int k = 1; k < 15; k++) begin
            w = (k <= 9) ? frame_word(k) : {8'hFF, IDLE_D};
            applyStimulus(w[71:64], w[63:0]);
            if (k == 5) checkOutput("dly5_not_early", 64'(rxd == 64'hD5555555555555FB), 64'h0);
            if (k == 6) begin
                checkOutput("dly5_start_rxd", rxd, 64'hD5555555555555FB);
                checkOutput("dly5_start_rxc", 64'(rxc), 64'h01);
            end
        end
        idles(5);

        // Local Fault requested mid-frame
        for (int i = 0; i < 10; i++) begin
            w = frame_word(i);
            applyStimulus(w[71:64], w[63:0]);
            if (i == 4) cfg_mode = 2'd2;
        end
        checkOutput("lf_pend_in_frame", 64'(cfg_pending), 64'h1);
        idles(10);
        checkOutput("lf_pend_held", 64'(cfg_pending), 64'h1);
        idles(25);
        checkOutput("lf_rxd", rxd, LF_D);
        checkOutput("lf_rxc", 64'(rxc), 64'h11);
        checkOutput("lf_pend_done", 64'(cfg_pending), 64'h0);

        // Start+Terminate in one word, then counter saturation
        cfg_mode = 2'd0;
        cfg_dly = 4'd0;
        idles(30);
        applyStimulus(sw[71:64], sw[63:0]);
        idles(1);
        checkOutput("st_same_word_cnt", 64'(frm_cnt), 64'h4);
        checkOutput("st_same_word_frame", 64'(in_frame), 64'h0);
        for (int i = 0; i < 65537; i++)
            applyStimulus(sw[71:64], sw[63:0]);
        idles(1);
        checkOutput("frm_cnt_saturated", 64'(frm_cnt), 64'hFFFF);

        // Reset mid-frame with a long delay
        cfg_dly = 4'd10;
        idles(30);
        for (int i = 0; i < 4; i++) begin
            w = frame_word(i);
            applyStimulus(w[71:64], w[63:0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_rxd", rxd, IDLE_D);
        checkOutput("async_rst_rxc", 64'(rxc), 64'hFF);
        checkOutput("async_rst_cnt", 64'(frm_cnt), 64'h0);
        checkOutput("async_rst_frame", 64'(in_frame), 64'h0);
        for (int i = 4; i < 7; i++) begin
            w = frame_word(i);
            applyStimulus(w[71:64], w[63:0]);
        end
        rst_n = 1'b1;
        for (int i = 7; i < 30; i++) begin
            w = (i <= 9) ? frame_word(i) : {8'hFF, IDLE_D};
            applyStimulus(w[71:64], w[63:0]);
            checkOutput("post_rst_idle", rxd, IDLE_D);
        end

`ifdef XGMII_LB_ERRINJ_EN
        // One-shot error injection into the first data word
        cfg_mode = 2'd0;
        cfg_dly = 4'd0;
        idles(30);
        inj_err = 1'b1;
        idles(1);
        inj_err = 1'b0;
        for (int i = 0; i < 10; i++) begin
            w = frame_word(i);
            applyStimulus(w[71:64], w[63:0]);
            if (i == 2) begin
                checkOutput("inj_lane0", 64'(rxd[7:0]), 64'hFE);
                checkOutput("inj_rxc0", 64'(rxc[0]), 64'h1);
                checkOutput("inj_upper", 64'(rxd[63:8]), 64'h11111111111111);
            end
        end
        idles(3);
        for (int i = 0; i < 10; i++) begin
            w = frame_word(i);
            applyStimulus(w[71:64], w[63:0]);
            if (i == 2) checkOutput("inj_clean_next", rxd, 64'h1111111111111111);
        end
        idles(3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
